// File: rtl/spi_cmd_exec.sv
// Command executor behind the SPI slave: decodes 24-bit {cmd, addr, payload} frames,
// maintains the LED brightness bank, drives PWM outputs and returns read bytes.
module spi_cmd_exec #(
  parameter int         NUM_LEDS     = 8,
  parameter logic [7:0] CMD_NOP      = 8'h00,
  parameter logic [7:0] CMD_LED_SET  = 8'h01,
  parameter logic [7:0] CMD_LED_READ = 8'h02,
  parameter int         PWM_DIV      = 4
) (
  input  logic                sysclk,
  input  logic                rst,
  input  logic                rx_dv,
  input  logic [23:0]         rx_frame,
  input  logic                tx_ready,
  output logic                tx_dv,
  output logic [7:0]          tx_byte,
  output logic                busy,
  output logic [NUM_LEDS-1:0] led_pwm,
  output logic [7:0]          err_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int                   AW         = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [8:0]           NUM_LEDS_W = 9'(NUM_LEDS);
  localparam int                   PRESC_W    = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [PRESC_W-1:0]   PRESC_MAX  = PRESC_W'(PWM_DIV - 1);
  localparam logic [6:0]           PWM_LAST   = 7'd126;

  logic [1:0]          r_state;
  logic [23:0]         r_frame;
  logic [6:0]          r_bright     [NUM_LEDS];
  logic [6:0]          r_bright_act [NUM_LEDS];
  logic                r_tx_dv;
  logic [7:0]          r_tx_byte;
  logic [7:0]          r_err_cnt;
  logic [PRESC_W-1:0]  r_presc;
  logic [6:0]          r_pwm_cnt;
  logic [NUM_LEDS-1:0] r_led_pwm;

  logic [7:0]    w_cmd;
  logic [7:0]    w_addr;
  logic [6:0]    w_new_bright;
  logic [AW-1:0] w_idx;
  logic          w_addr_ok;
  logic          w_exec_err;
  logic          w_overrun;
  logic          w_err_inc;
  logic          w_tick;
  logic          w_unused_payload_lsb;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it
  // unassigned; a missing default would silently infer a latch.
  always_comb begin
    w_cmd                = r_frame[23:16];
    w_addr               = r_frame[15:8];
    w_new_bright         = r_frame[7:1];
    w_unused_payload_lsb = r_frame[0];
    w_idx                = w_addr[AW-1:0];
    w_addr_ok            = ({1'b0, w_addr} < NUM_LEDS_W);
    w_exec_err           = 1'b0;
    if (r_state == ST_EXEC) begin
      if (w_cmd == CMD_LED_SET || w_cmd == CMD_LED_READ) begin
        w_exec_err = !w_addr_ok;
      end else if (w_cmd != CMD_NOP) begin
        w_exec_err = 1'b1;
      end
    end
    w_overrun = rx_dv && (r_state != ST_IDLE);
    // Simultaneous exec error and overrun still count as a single increment.
    w_err_inc = w_exec_err || w_overrun;
    w_tick    = (r_presc == PRESC_MAX);
  end

  // NOTE: state registers use non-blocking assignments only, so every always_ff
  // samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_frame   <= 24'h0;
      r_tx_dv   <= 1'b0;
      r_tx_byte <= 8'h00;
      r_err_cnt <= 8'h00;
      // NOTE: the brightness bank is a small register file that must read back as
      // zero after reset, so it is reset explicitly rather than left to a RAM.
      for (int i = 0; i < NUM_LEDS; i++) begin
        r_bright[i] <= 7'd0;
      end
    end else begin
      if (w_err_inc && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
      case (r_state)
        ST_IDLE: begin
          if (rx_dv) begin
            r_frame <= rx_frame;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_state <= ST_IDLE;
          if (w_cmd == CMD_LED_SET && w_addr_ok) begin
            r_bright[w_idx] <= w_new_bright;
          end else if (w_cmd == CMD_LED_READ) begin
            r_tx_dv   <= 1'b1;
            r_tx_byte <= w_addr_ok ? {r_bright[w_idx], 1'b0} : 8'h00;
            r_state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (tx_ready) begin
            r_tx_dv <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Shadow copies only update at the period wrap so a write never glitches a PWM cycle.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_presc   <= '0;
      r_pwm_cnt <= 7'd0;
      r_led_pwm <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        r_bright_act[i] <= 7'd0;
      end
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        r_led_pwm[i] <= (r_pwm_cnt < r_bright_act[i]);
      end
      if (w_tick) begin
        r_presc <= '0;
        if (r_pwm_cnt == PWM_LAST) begin
          r_pwm_cnt <= 7'd0;
          for (int i = 0; i < NUM_LEDS; i++) begin
            r_bright_act[i] <= r_bright[i];
          end
        end else begin
          r_pwm_cnt <= r_pwm_cnt + 7'd1;
        end
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  assign tx_dv   = r_tx_dv;
  assign tx_byte = r_tx_byte;
  assign busy    = (r_state != ST_IDLE);
  assign led_pwm = r_led_pwm;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_spi_cmd_exec.sv
// Self-checking bench for spi_cmd_exec: transaction-level reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_spi_cmd_exec;

  localparam int         NUM    = 8;
  localparam int         DIV    = 4;
  localparam int         PERIOD = 127 * DIV;
  localparam logic [7:0] NOP    = 8'h00;
  localparam logic [7:0] SET    = 8'h01;
  localparam logic [7:0] READ   = 8'h02;

  logic           sysclk = 1'b0;
  logic           rst;
  logic           rx_dv;
  logic [23:0]    rx_frame;
  logic           tx_ready;
  logic           tx_dv;
  logic [7:0]     tx_byte;
  logic           busy;
  logic [NUM-1:0] led_pwm;
  logic [7:0]     err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  spi_cmd_exec #(
    .NUM_LEDS(NUM), .CMD_NOP(NOP), .CMD_LED_SET(SET), .CMD_LED_READ(READ), .PWM_DIV(DIV)
  ) dut (
    .sysclk(sysclk), .rst(rst), .rx_dv(rx_dv), .rx_frame(rx_frame), .tx_ready(tx_ready),
    .tx_dv(tx_dv), .tx_byte(tx_byte), .busy(busy), .led_pwm(led_pwm), .err_cnt(err_cnt)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the frame in flight, the pending response and the
  // PWM position derived arithmetically from edges counted since reset release.
  int            m_edges;
  bit            m_have_frame;
  logic [23:0]   m_frame;
  bit            m_resp;
  logic [7:0]    m_tx_byte;
  logic [7:0]    m_err;
  logic [6:0]    m_bright [NUM];
  logic [6:0]    m_act    [NUM];
  logic [NUM-1:0] m_led;

  always @(posedge sysclk or posedge rst) begin
    if (rst) begin
      m_edges = 0; m_have_frame = 0; m_frame = '0; m_resp = 0;
      m_tx_byte = 8'h00; m_err = 8'h00; m_led = '0;
      for (int i = 0; i < NUM; i++) begin m_bright[i] = 7'd0; m_act[i] = 7'd0; end
    end else begin
      int  pos;
      bit  err_inc;
      logic [7:0] c, a;
      pos = (m_edges / DIV) % 127;
      for (int i = 0; i < NUM; i++) m_led[i] = (pos < int'(m_act[i]));
      m_edges++;
      if (m_edges % PERIOD == 0)
        for (int i = 0; i < NUM; i++) m_act[i] = m_bright[i];
      err_inc = 0;
      if (m_resp) begin
        if (rx_dv) err_inc = 1;
        if (tx_ready) m_resp = 0;
      end else if (m_have_frame) begin
        m_have_frame = 0;
        if (rx_dv) err_inc = 1;
        c = m_frame[23:16];
        a = m_frame[15:8];
        if (c == SET) begin
          if (a < NUM) m_bright[a] = m_frame[7:1]; else err_inc = 1;
        end else if (c == READ) begin
          m_resp = 1;
          if (a < NUM) m_tx_byte = {m_bright[a], 1'b0};
          else begin m_tx_byte = 8'h00; err_inc = 1; end
        end else if (c != NOP) begin
          err_inc = 1;
        end
      end else if (rx_dv) begin
        m_have_frame = 1;
        m_frame = rx_frame;
      end
      if (err_inc && m_err != 8'hFF) m_err = m_err + 8'd1;
    end
  end

  always @(negedge sysclk) begin
    if (cmp_en && !rst) begin
      check("busy", busy, m_have_frame | m_resp);
      check("tx_dv", tx_dv, m_resp);
      check("tx_byte", tx_byte, m_tx_byte);
      check("led_pwm", led_pwm, m_led);
      check("err_cnt", err_cnt, m_err);
    end
  end

  task automatic send(input logic [7:0] c, input logic [7:0] a, input logic [7:0] p);
    @(negedge sysclk);
    rx_dv = 1'b1; rx_frame = {c, a, p};
    @(negedge sysclk);
    rx_dv = 1'b0;
  endtask

  task automatic wait_resp(input string name, input logic [7:0] exp_byte);
    bit seen;
    seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge sysclk);
      if (tx_dv) begin
        seen = 1;
        check(name, tx_byte, exp_byte);
      end
    end
    check({name, "_seen"}, seen, 1'b1);
    @(negedge sysclk);
    check({name, "_drop"}, tx_dv, 1'b0);
  endtask

  task automatic do_reset(input string name);
    @(negedge sysclk);
    #2;
    rst = 1'b1; rx_dv = 1'b0;
    #1;
    check({name, "_tx_dv"}, tx_dv, 1'b0);
    check({name, "_tx_byte"}, tx_byte, 8'h00);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_led"}, led_pwm, '0);
    check({name, "_err"}, err_cnt, 8'h00);
    @(negedge sysclk);
    rst = 1'b0;
  endtask

  function automatic logic [23:0] rand_frame();
    logic [7:0] c, a, p;
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) c = NOP;
    else if (r <= 4) c = SET;
    else if (r <= 7) c = READ;
    else c = 8'($urandom_range(0, 255));
    a = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, NUM - 1)) : 8'($urandom_range(0, 255));
    p = 8'($urandom_range(0, 255));
    return {c, a, p};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0, cnt1, cnt7;
    rst = 1'b0; rx_dv = 1'b0; rx_frame = '0; tx_ready = 1'b1;
    #1 rst = 1'b1;
    repeat (2) @(negedge sysclk);
    rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge sysclk);
    check("init_err", err_cnt, 8'h00);
    check("init_led", led_pwm, '0);
    check("init_tx_dv", tx_dv, 1'b0);

    send(NOP, 8'h00, 8'h00);
    repeat (3) @(negedge sysclk);
    check("nop_busy", busy, 1'b0);

    send(SET, 8'h00, 8'h14);
    send(SET, 8'h07, 8'hFE);
    repeat (2) @(negedge sysclk);

    send(SET, 8'h10, 8'hFF);
    repeat (2) @(negedge sysclk);
    check("bad_addr_err", err_cnt, 8'd1);
    send(8'h55, 8'h00, 8'h00);
    repeat (2) @(negedge sysclk);
    check("bad_op_err", err_cnt, 8'd2);

    // Held response with an overrun frame arriving mid-RESP.
    tx_ready = 1'b0;
    send(READ, 8'h07, 8'h0C);
    for (int i = 0; i < 5; i++) begin
      @(negedge sysclk);
      check("held_tx_dv", tx_dv, 1'b1);
      check("held_tx_byte", tx_byte, 8'hFE);
      if (i == 1) begin rx_dv = 1'b1; rx_frame = {SET, 8'h00, 8'h00}; end
      else rx_dv = 1'b0;
    end
    check("overrun_err", err_cnt, 8'd3);
    tx_ready = 1'b1;
    @(negedge sysclk);
    check("accept_tx_dv", tx_dv, 1'b0);
    check("accept_busy", busy, 1'b0);

    send(READ, 8'h00, 8'h00);
    wait_resp("rd0", 8'h14);
    send(READ, 8'h10, 8'h00);
    wait_resp("rd_bad", 8'h00);
    check("rd_bad_err", err_cnt, 8'd4);

    repeat (PERIOD + 12) @(negedge sysclk);
    cnt0 = 0; cnt1 = 0; cnt7 = 0;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge sysclk);
      cnt0 += int'(led_pwm[0]);
      cnt1 += int'(led_pwm[1]);
      cnt7 += int'(led_pwm[7]);
    end
    check("pwm0_high", cnt0, 40);
    check("pwm1_high", cnt1, 0);
    check("pwm7_high", cnt7, PERIOD);

    tx_ready = 1'b0;
    send(READ, 8'h07, 8'h00);
    repeat (3) @(negedge sysclk);
    do_reset("rst_resp");
    tx_ready = 1'b1;
    send(READ, 8'h07, 8'h00);
    wait_resp("rd7_after_rst", 8'h00);
    send(SET, 8'h03, 8'h40);
    repeat (2) @(negedge sysclk);
    send(READ, 8'h03, 8'h00);
    wait_resp("rd3_after_rst", 8'h40);
    check("err_after_rst", err_cnt, 8'h00);

    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset("rst_rand");
      @(negedge sysclk);
      rx_dv    = ($urandom_range(0, 3) == 0);
      rx_frame = rand_frame();
      tx_ready = ($urandom_range(0, 1) == 1);
    end
    @(negedge sysclk);
    rx_dv = 1'b0; tx_ready = 1'b1;
    repeat (10) @(negedge sysclk);
    check("final_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
